// File: rtl/axi_s2mm_ring_pkg.sv
// rtl/axi_s2mm_ring_pkg.sv - shared states, response codes and length alignment for the s2mm ring controller
package axi_s2mm_ring_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SPACE,
        ST_TRIG,
        ST_WAIT,
        ST_COMMIT,
        ST_ERR
    } ring_state_t;

    localparam logic [1:0] RESP_NONE   = 2'd0;
    localparam logic [1:0] RESP_OKAY   = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Ring footprint of a packet: (len_m1 + align) floored to an align multiple,
    // which equals the byte count rounded up to the next align multiple.
    function automatic logic [16:0] align_len(input logic [15:0] len_m1, input logic [16:0] align);
        logic [16:0] sum;
        sum = {1'b0, len_m1} + align;
        return sum & ~(align - 17'd1);
    endfunction

endpackage

// File: rtl/ring_space_calc.sv
// rtl/ring_space_calc.sv - combinational tail-fit, wrap and free-space admission check for the ring
module ring_space_calc #(
    parameter int C_RING_BITS = 20
) (
    input  logic [C_RING_BITS-1:0] wr,
    input  logic [C_RING_BITS-1:0] rd,
    input  logic [C_RING_BITS-1:0] size,
    input  logic [16:0]            alen,
    output logic                   fits,
    output logic                   wrap,
    output logic                   ok
);

    localparam int W = C_RING_BITS + 1;

    logic [W-1:0] wr_w;
    logic [W-1:0] rd_w;
    logic [W-1:0] size_w;
    logic [W-1:0] alen_w;
    logic [W-1:0] free;

    assign wr_w   = {1'b0, wr};
    assign rd_w   = {1'b0, rd};
    assign size_w = {1'b0, size};
    assign alen_w = W'(alen);

    assign fits = (alen_w <= size_w - wr_w);
    assign wrap = ~fits;

    // One byte is always kept free so that rd == wr unambiguously means empty.
    always_comb begin
        free = '0;
        ok   = 1'b0;
        if (rd_w > wr_w)
            free = rd_w - wr_w - 1'b1;
        else
            free = size_w - wr_w + rd_w - 1'b1;
        if (fits)
            ok = (alen_w <= free);
        else
            ok = (rd_w == wr_w) || ((rd_w < wr_w) && (alen_w < rd_w));
    end

endmodule

// File: rtl/axi_s2mm_ring_ctrl.sv
// rtl/axi_s2mm_ring_ctrl.sv - ring-buffer command sequencer for axi_s2mm_io (optional counters: AXI_S2MM_RING_STATS_EN)
module axi_s2mm_ring_ctrl
    import axi_s2mm_ring_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 64,
    parameter int C_RING_BITS      = 20,
    parameter int C_ALIGN          = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [C_AXI_ADDR_WIDTH-1:0] ring_base,
    input  logic [C_RING_BITS-1:0]      ring_size,
    input  logic [C_RING_BITS-1:0]      read_ptr,
    input  logic [15:0]                 s_len_tdata,
    input  logic                        s_len_tvalid,
    output logic                        s_len_tready,
    output logic                        io_trigger,
    output logic [C_AXI_ADDR_WIDTH-1:0] io_start_addr,
    output logic [15:0]                 io_bytes_to_write,
    input  logic                        io_busy,
    input  logic [1:0]                  io_response,
    output logic [C_RING_BITS-1:0]      write_ptr,
    output logic [C_RING_BITS-1:0]      wrap_mark,
    output logic                        pkt_done,
`ifdef AXI_S2MM_RING_STATS_EN
    output logic [31:0]                 stat_packets,
    output logic [47:0]                 stat_bytes,
`endif
    output logic                        error
);

    localparam int RW = C_RING_BITS + 1;

    ring_state_t            state;
    ring_state_t            state_nxt;
    logic [15:0]            len_q;
    logic [16:0]            alen;
    logic [C_RING_BITS-1:0] target_q;
    logic                   wrap_q;
    logic                   busy_seen;
    logic                   fits;
    logic                   wrap;
    logic                   space_ok;
    logic                   too_big;
    logic [RW-1:0]          commit_sum;
    logic [C_RING_BITS-1:0] commit_ptr;

    assign alen       = align_len(len_q, 17'(C_ALIGN));
    assign too_big    = (RW'(alen) >= {1'b0, ring_size});
    assign commit_sum = {1'b0, target_q} + RW'(alen);
    assign commit_ptr = (commit_sum == {1'b0, ring_size}) ? '0 : commit_sum[C_RING_BITS-1:0];

    ring_space_calc #(
        .C_RING_BITS(C_RING_BITS)
    ) u_space (
        .wr  (write_ptr),
        .rd  (read_ptr),
        .size(ring_size),
        .alen(alen),
        .fits(fits),
        .wrap(wrap),
        .ok  (space_ok)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and single-cycle handshake/pulse outputs.
    always_comb begin
        state_nxt    = state;
        s_len_tready = 1'b0;
        io_trigger   = 1'b0;
        pkt_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                s_len_tready = enable & ~error;
                if (enable && !error && s_len_tvalid)
                    state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = too_big ? ST_ERR : ST_SPACE;
            end
            ST_SPACE: begin
                // A disabled block drops the pending descriptor rather than trigger.
                if (!enable)
                    state_nxt = ST_IDLE;
                else if (space_ok && !io_busy)
                    state_nxt = ST_TRIG;
            end
            ST_TRIG: begin
                io_trigger = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (busy_seen && !io_busy) begin
                    case (io_response)
                        RESP_NONE, RESP_OKAY:     state_nxt = ST_COMMIT;
                        RESP_SLVERR, RESP_DECERR: state_nxt = ST_ERR;
                        default:                  state_nxt = ST_COMMIT;
                    endcase
                end
            end
            ST_COMMIT: begin
                pkt_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (!enable)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Descriptor latch, placement decision, command outputs, pointer commit and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q             <= '0;
            target_q          <= '0;
            wrap_q            <= 1'b0;
            busy_seen         <= 1'b0;
            io_start_addr     <= '0;
            io_bytes_to_write <= '0;
            write_ptr         <= '0;
            wrap_mark         <= '0;
            error             <= 1'b0;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_CHECK)
                len_q <= s_len_tdata;

            if (state == ST_CHECK) begin
                target_q <= fits ? write_ptr : '0;
                wrap_q   <= wrap;
            end

            if (state == ST_SPACE && state_nxt == ST_TRIG) begin
                io_start_addr     <= ring_base + C_AXI_ADDR_WIDTH'(target_q);
                io_bytes_to_write <= len_q;
            end

            if (state == ST_TRIG)
                busy_seen <= 1'b0;
            else if (state == ST_WAIT && io_busy)
                busy_seen <= 1'b1;

            if (state == ST_COMMIT) begin
                write_ptr <= commit_ptr;
                if (wrap_q)
                    wrap_mark <= write_ptr;
            end

            if ((state == ST_CHECK && too_big) || (state == ST_WAIT && state_nxt == ST_ERR))
                error <= 1'b1;
            else if (!enable && (state == ST_ERR || state == ST_IDLE))
                error <= 1'b0;
        end
    end

`ifdef AXI_S2MM_RING_STATS_EN
    // Committed packet and byte counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_packets <= '0;
            stat_bytes   <= '0;
        end else if (state == ST_COMMIT) begin
            stat_packets <= stat_packets + 32'd1;
            stat_bytes   <= stat_bytes + 48'(len_q) + 48'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_s2mm_ring_ctrl.sv
// tb/tb_axi_s2mm_ring_ctrl.sv - directed self-checking bench for axi_s2mm_ring_ctrl
module tb_axi_s2mm_ring_ctrl;

    localparam logic [63:0] BASE = 64'h0000_0001_2340_0000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [63:0] ring_base;
    logic [19:0] ring_size;
    logic [19:0] read_ptr;
    logic [15:0] s_len_tdata;
    logic        s_len_tvalid;
    logic        s_len_tready;
    logic        io_trigger;
    logic [63:0] io_start_addr;
    logic [15:0] io_bytes_to_write;
    logic        io_busy;
    logic [1:0]  io_response;
    logic [19:0] write_ptr;
    logic [19:0] wrap_mark;
    logic        pkt_done;
    logic        error;
`ifdef AXI_S2MM_RING_STATS_EN
    logic [31:0] stat_packets;
    logic [47:0] stat_bytes;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    axi_s2mm_ring_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .ring_base        (ring_base),
        .ring_size        (ring_size),
        .read_ptr         (read_ptr),
        .s_len_tdata      (s_len_tdata),
        .s_len_tvalid     (s_len_tvalid),
        .s_len_tready     (s_len_tready),
        .io_trigger       (io_trigger),
        .io_start_addr    (io_start_addr),
        .io_bytes_to_write(io_bytes_to_write),
        .io_busy          (io_busy),
        .io_response      (io_response),
        .write_ptr        (write_ptr),
        .wrap_mark        (wrap_mark),
        .pkt_done         (pkt_done),
`ifdef AXI_S2MM_RING_STATS_EN
        .stat_packets     (stat_packets),
        .stat_bytes       (stat_bytes),
`endif
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input string tag, input logic [15:0] len_m1);
        bit done;
        done = 1'b0;
        s_len_tdata  = len_m1;
        s_len_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (s_len_tready)
                done = 1'b1;
            tick();
        end
        s_len_tvalid = 1'b0;
        check({tag, "_accept"}, done, 1);
    endtask

    task automatic wait_trigger(input string tag, input int budget, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (io_trigger)
                seen = 1'b1;
            else begin
                tick();
                cycles++;
            end
        end
        check({tag, "_trig"}, seen, 1);
    endtask

    task automatic no_trigger(input string tag, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            if (io_trigger)
                hits++;
            tick();
        end
        check(tag, hits, 0);
    endtask

    // Plays axi_s2mm_io: busy for three cycles, response presented on the fall.
    task automatic transfer(input string tag, input logic [1:0] resp);
        tick();
        check({tag, "_trig_pulse"}, io_trigger, 0);
        io_busy = 1'b1;
        tick();
        tick();
        tick();
        io_busy     = 1'b0;
        io_response = resp;
        tick();
        io_response = 2'd0;
        check({tag, "_pkt_done"}, pkt_done, (resp < 2'd2) ? 1 : 0);
    endtask

    task automatic packet(input string tag, input logic [15:0] len_m1, input logic [19:0] rd,
                          input logic [63:0] exp_addr, input logic [19:0] exp_wp);
        int cyc;
        read_ptr = rd;
        send_desc(tag, len_m1);
        wait_trigger(tag, 20, cyc);
        check({tag, "_addr"}, io_start_addr, exp_addr);
        check({tag, "_bytes"}, io_bytes_to_write, len_m1);
        transfer(tag, 2'd1);
        tick();
        check({tag, "_wp"}, write_ptr, exp_wp);
    endtask

    initial begin
        int cyc;
        rst_n        = 1'b0;
        enable       = 1'b0;
        ring_base    = BASE;
        ring_size    = 20'h1000;
        read_ptr     = '0;
        s_len_tdata  = '0;
        s_len_tvalid = 1'b0;
        io_busy      = 1'b0;
        io_response  = 2'd0;
        tick();
        tick();
        check("rst_tready", s_len_tready, 0);
        check("rst_trigger", io_trigger, 0);
        check("rst_addr", io_start_addr, 0);
        check("rst_bytes", io_bytes_to_write, 0);
        check("rst_wp", write_ptr, 0);
        check("rst_wrap_mark", wrap_mark, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        check("idle_tready", s_len_tready, 1);

        // 100-byte packet into an empty ring
        read_ptr = 20'h0;
        send_desc("t1", 16'h0063);
        wait_trigger("t1", 20, cyc);
        check("t1_latency", cyc, 2);
        check("t1_addr", io_start_addr, BASE);
        check("t1_bytes", io_bytes_to_write, 16'h0063);
        transfer("t1", 2'd1);
        tick();
        check("t1_wp", write_ptr, 20'h70);
        check("t1_done_single", pkt_done, 0);
        check("t1_tready_after", s_len_tready, 1);
        check("t1_wrap_mark", wrap_mark, 0);

        // advance the producer to 0xFC0
        packet("fill", 16'h0F4F, 20'h70, BASE + 64'h70, 20'hFC0);

        // tail too short: wrap must wait for the reader
        read_ptr = 20'hFE0;
        send_desc("t2", 16'h007F);
        no_trigger("t2_rd_ahead_stall", 10);
        read_ptr = 20'h040;
        no_trigger("t2_rd_small_stall", 10);
        read_ptr = 20'hFC0;
        wait_trigger("t2", 20, cyc);
        check("t2_addr", io_start_addr, BASE);
        transfer("t2", 2'd1);
        tick();
        check("t2_wp", write_ptr, 20'h80);
        check("t2_wrap_mark", wrap_mark, 20'hFC0);

        packet("t3", 16'h007F, 20'h80, BASE + 64'h80, 20'h100);

        // free = 0x7F < 0x80 stalls, free = 0x8F proceeds
        read_ptr = 20'h180;
        send_desc("t4", 16'h007F);
        no_trigger("t4_free_stall", 10);
        read_ptr = 20'h190;
        wait_trigger("t4", 20, cyc);
        check("t4_addr", io_start_addr, BASE + 64'h100);
        transfer("t4", 2'd1);
        tick();
        check("t4_wp", write_ptr, 20'h180);

        // packet ending exactly at ring_size commits write_ptr = 0
        packet("t5", 16'h0E7F, 20'h180, BASE + 64'h180, 20'h0);
        check("t5_wrap_mark", wrap_mark, 20'hFC0);

        // SLVERR on the busy fall
        read_ptr = 20'h0;
        send_desc("t6", 16'h000F);
        wait_trigger("t6", 20, cyc);
        check("t6_addr", io_start_addr, BASE);
        transfer("t6", 2'd2);
        check("t6_error", error, 1);
        tick();
        check("t6_error_sticky", error, 1);
        check("t6_tready", s_len_tready, 0);
        check("t6_wp", write_ptr, 20'h0);
        enable = 1'b0;
        tick();
        check("t6_error_clr", error, 0);
        enable = 1'b1;
        tick();
        check("t6_tready_back", s_len_tready, 1);

        // alen == ring_size is rejected
        send_desc("t7", 16'h0FF0);
        tick();
        check("t7_error", error, 1);
        no_trigger("t7_no_trig", 5);
        check("t7_tready", s_len_tready, 0);
        enable = 1'b0;
        tick();
        check("t7_error_clr", error, 0);
        enable = 1'b1;
        tick();

        // io_busy held high externally blocks the trigger
        io_busy  = 1'b1;
        read_ptr = 20'h0;
        send_desc("t8", 16'h001F);
        no_trigger("t8_busy_stall", 10);
        io_busy = 1'b0;
        wait_trigger("t8", 20, cyc);
        check("t8_addr", io_start_addr, BASE);
        check("t8_bytes", io_bytes_to_write, 16'h001F);
        transfer("t8", 2'd1);
        tick();
        check("t8_wp", write_ptr, 20'h20);

        // disabled block refuses descriptors
        enable = 1'b0;
        tick();
        check("t9_tready", s_len_tready, 0);
        s_len_tdata  = 16'h0010;
        s_len_tvalid = 1'b1;
        no_trigger("t9_no_trig", 6);
        s_len_tvalid = 1'b0;
        check("t9_wp", write_ptr, 20'h20);

`ifdef AXI_S2MM_RING_STATS_EN
        enable = 1'b1;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("st_pkts_rst", stat_packets, 0);
        check("st_bytes_rst", stat_bytes, 0);
        packet("st1", 16'h0063, 20'h0, BASE, 20'h70);
        packet("st2", 16'h0063, 20'h0, BASE + 64'h70, 20'hE0);
        packet("st3", 16'h0063, 20'h0, BASE + 64'hE0, 20'h150);
        check("st_pkts", stat_packets, 3);
        check("st_bytes", stat_bytes, 300);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
